// File: rtl/inst_encoder_pkg.sv
// Shared instruction-word definitions for the MCU encoder/decoder pair:
// opcode values, word width, and the host-side command kind codes.
package inst_encoder_pkg;

    localparam int INST_W = 20;

    // SET is the only 2-bit opcode. The 4-bit opcodes must never start with it.
    localparam logic [1:0] OPC_SET    = 2'b11;
    localparam logic [3:0] OPC_CPY    = 4'h0;
    localparam logic [3:0] OPC_CPYIR  = 4'h1;
    localparam logic [3:0] OPC_CPYRI  = 4'h2;
    localparam logic [3:0] OPC_CALL   = 4'h3;
    localparam logic [3:0] OPC_RETURN = 4'h4;
    localparam logic [3:0] OPC_WAIT   = 4'h5;
    localparam logic [3:0] OPC_JMP    = 4'h6;

    typedef enum logic [2:0] {
        K_SET    = 3'd0,
        K_CPY    = 3'd1,
        K_CPYIR  = 3'd2,
        K_CPYRI  = 3'd3,
        K_CALL   = 3'd4,
        K_RETURN = 3'd5,
        K_WAIT   = 3'd6,
        K_JMP    = 3'd7
    } cmd_kind_e;

    function automatic logic opc_alias_free();
        logic [3:0] opcs [7];
        logic       ok;
        opcs = '{OPC_CPY, OPC_CPYIR, OPC_CPYRI, OPC_CALL, OPC_RETURN, OPC_WAIT, OPC_JMP};
        ok = 1'b1;
        for (int i = 0; i < 7; i++)
            if (opcs[i][3:2] == OPC_SET) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational field-to-word packer; flags commands that carry stray operand bits.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [15:0]       f0,
    input  logic [9:0]        f1,
    input  logic              med,
    input  logic [1:0]        unit,
    output logic [INST_W-1:0] word,
    output logic              illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cmd_kind_e'(op))
            K_SET: begin
                word    = {OPC_SET, f0[7:0], f1};
                illegal = |f0[15:8];
            end
            K_CPY: begin
                word    = {OPC_CPY, f0[7:0], f1[7:0]};
                illegal = (|f0[15:8]) | (|f1[9:8]);
            end
            K_CPYIR: begin
                word    = {OPC_CPYIR, f0[7:0], f1[7:0]};
                illegal = (|f0[15:8]) | (|f1[9:8]);
            end
            K_CPYRI: begin
                word    = {OPC_CPYRI, f0[7:0], f1[7:0]};
                illegal = (|f0[15:8]) | (|f1[9:8]);
            end
            K_CALL:   word = {OPC_CALL, f0};
            K_JMP:    word = {OPC_JMP, f0};
            K_RETURN: begin
                word    = {OPC_RETURN, 16'h0000};
                illegal = (|f0) | (|f1) | med | (|unit);
            end
            K_WAIT: begin
                word    = {OPC_WAIT, med, unit, 5'b00000, f1[7:0]};
                illegal = |f1[9:8];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Program loader: packs host commands and streams them into instruction memory
// at consecutive addresses through a single output register.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_start,
    input  logic              prog_end,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [15:0]       cmd_f0,
    input  logic [9:0]        cmd_f1,
    input  logic              cmd_med,
    input  logic [1:0]        cmd_unit,
    output logic              imem_wvalid,
    input  logic              imem_wready,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [19:0]       imem_wdata,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic [ADDR_W:0]   prog_len,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    if (!opc_alias_free()) begin : g_opc_check
        $error("inst_encoder: a 4-bit opcode aliases the SET prefix");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;
    state_e state;

    logic [INST_W-1:0] pk_word;
    logic              pk_illegal;
    logic [ADDR_W:0]   rsv;      // legal words accepted this load, written or pending
    logic              accept, wr_fire;

    inst_pack u_pack (
        .op      (cmd_op),
        .f0      (cmd_f0),
        .f1      (cmd_f1),
        .med     (cmd_med),
        .unit    (cmd_unit),
        .word    (pk_word),
        .illegal (pk_illegal)
    );

    // rsv stops a command being taken while the last free slot is still in flight.
    assign cmd_ready = (state == LOAD) & !full & (rsv != DEPTH) & (!imem_wvalid | imem_wready);
    assign accept    = cmd_valid & cmd_ready;
    assign wr_fire   = imem_wvalid & imem_wready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            imem_wvalid <= 1'b0;
            imem_waddr  <= BASE_ADDR;
            imem_wdata  <= '0;
            full        <= 1'b0;
            done        <= 1'b0;
            prog_len    <= '0;
            err         <= 1'b0;
            rsv         <= '0;
        end else begin
            done <= 1'b0;
            if (wr_fire) begin
                imem_wvalid <= 1'b0;
                prog_len    <= prog_len + 1'b1;
                full        <= (prog_len + 1'b1 == DEPTH);
                imem_waddr  <= (prog_len + 1'b1 == DEPTH) ? BASE_ADDR : imem_waddr + 1'b1;
            end
            if (accept) begin
                if (pk_illegal) begin
                    err <= 1'b1;
                end else begin
                    imem_wvalid <= 1'b1;
                    imem_wdata  <= pk_word;
                    rsv         <= rsv + 1'b1;
                end
            end
            case (state)
                IDLE: if (prog_start) begin
                    state      <= LOAD;
                    prog_len   <= '0;
                    err        <= 1'b0;
                    full       <= 1'b0;
                    rsv        <= '0;
                    imem_waddr <= BASE_ADDR;
                end
                LOAD: if (prog_end) state <= DRAIN;
                DRAIN: if (!imem_wvalid) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
